// File: rtl/hex_timer_ctrl_pkg.sv
// Shared definitions for the interval timer controller: state encoding and default width.
package hex_timer_ctrl_pkg;

  localparam int unsigned WIDTH_DEF = 4;

  // 2'd3 is unreachable; the controller treats it as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/hex_timer_cnt.sv
// Enable-chained binary counter built from per-bit toggle stages.
// clr has priority over en. res is an asynchronous clear.
module hex_timer_cnt
  import hex_timer_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             res,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] tgl;

  // Stage i toggles when en is high and all lower bits are 1.
  always_comb begin
    logic acc;
    acc = en;
    tgl = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      tgl[i] = acc;
      acc    = acc & q[i];
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else begin
      q <= q ^ tgl;
    end
  end

endmodule

// File: rtl/hex_timer_ctrl.sv
// Interval timer controller: sequences the counter through IDLE/RUN/DONE and
// produces one-cycle start_ack and terminal-count tick pulses.
module hex_timer_ctrl
  import hex_timer_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] tc_val,
  output logic             start_ack,
  output logic             busy,
  output logic             done,
  output logic             tick,
  output logic [WIDTH-1:0] q
);

  state_t           state;
  logic [WIDTH-1:0] tc_reg;
  logic             mode_reg;
  logic             cnt_clr;
  logic             cnt_en;
  logic             tc_hit;
  logic             accept;

  assign tc_hit = (q == tc_reg);
  assign accept = start & ~stop & (state != ST_RUN);

  // Counter control is derived from the same sampled inputs as the FSM, so the
  // counter and the state register move together on each edge.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state)
      ST_IDLE: cnt_clr = start & ~stop;
      ST_RUN: begin
        if (stop) begin
          cnt_clr = 1'b1;
        end else if (!pause) begin
          if (tc_hit) begin
            cnt_clr = mode_reg;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      ST_DONE: cnt_clr = start | stop;
      default: cnt_clr = 1'b1;
    endcase
  end

  hex_timer_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk (clk),
    .res (res),
    .clr (cnt_clr),
    .en  (cnt_en),
    .q   (q)
  );

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state     <= ST_IDLE;
      tc_reg    <= '0;
      mode_reg  <= 1'b0;
      start_ack <= 1'b0;
      tick      <= 1'b0;
    end else begin
      start_ack <= 1'b0;
      tick      <= 1'b0;
      if (accept) begin
        tc_reg   <= tc_val;
        mode_reg <= mode;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            start_ack <= 1'b1;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_IDLE;
          end else if (!pause && tc_hit) begin
            tick <= 1'b1;
            if (!mode_reg) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (stop) begin
            state <= ST_IDLE;
          end else if (accept) begin
            start_ack <= 1'b1;
            state     <= ST_RUN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_hex_timer_ctrl.sv
// Self-checking bench for hex_timer_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_hex_timer_ctrl;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         res;
  logic         start, stop, pause, mode;
  logic [W-1:0] tc_val;
  logic         start_ack, busy, done, tick;
  logic [W-1:0] q;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: running/finished flags, count, latched terminal count.
  bit           m_running, m_finished, m_periodic, m_ack, m_tick;
  int unsigned  m_q, m_tc;

  always #5 clk = ~clk;

  hex_timer_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .res       (res),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .mode      (mode),
    .tc_val    (tc_val),
    .start_ack (start_ack),
    .busy      (busy),
    .done      (done),
    .tick      (tick),
    .q         (q)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_running = 0; m_finished = 0; m_periodic = 0;
    m_ack = 0; m_tick = 0; m_q = 0; m_tc = 0;
  endtask

  task automatic check_all();
    chk("q", 32'(q), m_q);
    chk("busy", 32'(busy), 32'(m_running));
    chk("done", 32'(done), 32'(m_finished));
    chk("tick", 32'(tick), 32'(m_tick));
    chk("start_ack", 32'(start_ack), 32'(m_ack));
  endtask

  // Apply one cycle of inputs, advance the model, compare on the falling edge.
  task automatic step(input bit s, input bit st, input bit p, input bit md, input int unsigned tv);
    bit was_run, was_fin;
    start = s; stop = st; pause = p; mode = md; tc_val = W'(tv);
    @(posedge clk);
    was_run = m_running; was_fin = m_finished;
    m_ack = 0; m_tick = 0;
    if (!was_run && s && !st) begin
      m_tc = tv; m_periodic = md; m_q = 0; m_ack = 1;
      m_running = 1; m_finished = 0;
    end else if (was_run) begin
      if (st) begin
        m_running = 0; m_q = 0;
      end else if (!p) begin
        if (m_q == m_tc) begin
          m_tick = 1;
          if (m_periodic) m_q = 0;
          else begin m_running = 0; m_finished = 1; end
        end else begin
          m_q = m_q + 1;
        end
      end
    end else if (was_fin && st) begin
      m_finished = 0; m_q = 0;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    int tick_gap;
    res = 1'b1; start = 0; stop = 0; pause = 0; mode = 0; tc_val = '0;
    model_reset();
    repeat (2) @(negedge clk);
    res = 1'b0;
    check_all();

    // Periodic tc=3, with a start attempt mid-run that must be ignored.
    step(1, 0, 0, 1, 3);
    idle_steps(5);
    step(1, 0, 0, 0, 1);
    idle_steps(8);
    step(0, 1, 0, 0, 0);

    // One-shot tc=2, then restart from DONE with tc=1.
    step(1, 0, 0, 0, 2);
    idle_steps(5);
    step(1, 0, 0, 0, 1);
    idle_steps(4);
    step(0, 1, 0, 0, 0);
    idle_steps(1);

    // Pause at q=4, then stop exactly at the terminal count.
    step(1, 0, 0, 1, 7);
    for (int i = 0; i < 16 && m_q != 4; i++) step(0, 0, 0, 0, 0);
    chk("pause_q4", 32'(q), 32'd4);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("resume_q5", 32'(q), 32'd5);
    for (int i = 0; i < 16 && m_q != 7; i++) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("stop_at_tc_tick", 32'(tick), 32'd0);

    // start and stop together in IDLE.
    step(1, 1, 0, 1, 5);
    idle_steps(2);

    // tc=0 periodic: tick every cycle.
    step(1, 0, 0, 1, 0);
    idle_steps(6);
    step(0, 1, 0, 0, 0);

    // Full-range tc=15 periodic: tick period 16.
    step(1, 0, 0, 1, 15);
    tick_gap = -1;
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0, 0, 0);
      if (tick) begin
        if (tick_gap >= 0) chk("tick_period16", 32'(tick_gap), 32'd16);
        tick_gap = 0;
      end
      if (tick_gap >= 0) tick_gap++;
    end
    step(0, 1, 0, 0, 0);

    // Asynchronous reset mid-count at q=3.
    step(1, 0, 0, 1, 5);
    for (int i = 0; i < 16 && m_q != 3; i++) step(0, 0, 0, 0, 0);
    #2 res = 1'b1;
    #1;
    model_reset();
    chk("async_rst_q", 32'(q), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_tick", 32'(tick), 32'd0);
    @(negedge clk);
    res = 1'b0;
    check_all();
    idle_steps(3);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, (1 << W) - 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
